alu_cmd_responder: RTL and testbench



---
 rtl/alu_cmd_responder_if.sv | 28 ++
 rtl/alu_cmd_responder.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_responder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_responder_if.sv
// rtl/alu_cmd_responder_if.sv - request/response channel bundle for the ALU command responder
interface alu_cmd_responder_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_opcode;
    logic             req_mode;
    logic             req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_opcode, req_mode, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, req_mode, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - pipelined ALU responder with in-order response FIFO
// Optional stat_ops/stat_errs counters enabled by macro ALU_RSP_STATS_EN.
module alu_cmd_responder #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_cmd_responder_if.slave   bus
`ifdef ALU_RSP_STATS_EN
    ,
    output logic [31:0]          stat_ops,
    output logic [15:0]          stat_errs
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + 3;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic             r_init;
    logic             r_stg_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_op;
    logic             r_mode;
    logic             r_cin;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];

    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_rsp_valid;
    logic [CNT_W-1:0] w_credit_used;
    logic [WIDTH:0]   w_ext_a;
    logic [WIDTH:0]   w_ext_b;
    logic [WIDTH:0]   w_ext_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_zero;
    logic             w_err;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_head;

    // Credit counts the in-flight stage so a push can never find the FIFO full.
    assign w_credit_used = r_count + CNT_W'(r_stg_valid);
    assign bus.req_ready = r_init && (w_credit_used < DEPTH_C);
    assign w_req_fire    = bus.req_valid && bus.req_ready;
    assign w_push        = r_stg_valid;
    assign w_rsp_valid   = (r_count != '0);
    assign w_pop         = w_rsp_valid && bus.rsp_ready;

    assign w_ext_a   = {1'b0, r_a};
    assign w_ext_b   = {1'b0, r_b};
    assign w_ext_cin = {{WIDTH{1'b0}}, r_cin};

    always_comb begin
        w_sum    = '0;
        w_result = '0;
        w_cout   = 1'b0;
        w_err    = 1'b0;
        if (!r_mode) begin
            // Bit WIDTH of the extended result is the carry or, for subtraction, the borrow.
            case (r_op)
                4'b0000: w_sum = w_ext_a + w_ext_b + w_ext_cin;
                4'b0001: w_sum = w_ext_a - w_ext_b - w_ext_cin;
                4'b0011: w_sum = w_ext_a + (WIDTH+1)'(1);
                4'b0100: w_sum = w_ext_a - (WIDTH+1)'(1);
                default: w_err = 1'b1;
            endcase
            w_result = w_sum[WIDTH-1:0];
            w_cout   = w_sum[WIDTH];
        end else begin
            case (r_op)
                4'b0101: w_result = r_a & r_b;
                4'b0110: w_result = r_a | r_b;
                4'b0111: w_result = r_a ^ r_b;
                4'b1000: w_result = ~r_a;
                default: w_err    = 1'b1;
            endcase
        end
    end

    assign w_zero  = (w_result == '0);
    assign w_entry = {w_err, w_zero, w_cout, w_result};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init      <= 1'b0;
            r_stg_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_mode      <= 1'b0;
            r_cin       <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_init      <= 1'b1;
            r_stg_valid <= w_req_fire;
            if (w_req_fire) begin
                r_a    <= bus.req_a;
                r_b    <= bus.req_b;
                r_op   <= bus.req_opcode;
                r_mode <= bus.req_mode;
                r_cin  <= bus.req_cin;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Head fields are masked when empty so outputs read zero after reset.
    assign w_head         = r_mem[r_rd_ptr];
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = w_rsp_valid ? w_head[WIDTH-1:0] : '0;
    assign bus.rsp_cout   = w_rsp_valid && w_head[WIDTH];
    assign bus.rsp_zero   = w_rsp_valid && w_head[WIDTH+1];
    assign bus.rsp_err    = w_rsp_valid && w_head[WIDTH+2];

`ifdef ALU_RSP_STATS_EN
    logic [31:0] r_stat_ops;
    logic [15:0] r_stat_errs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_ops  <= '0;
            r_stat_errs <= '0;
        end else begin
            if (w_pop && (r_stat_ops != '1)) begin
                r_stat_ops <= r_stat_ops + 32'd1;
            end
            if (w_pop && bus.rsp_err && (r_stat_errs != '1)) begin
                r_stat_errs <= r_stat_errs + 16'd1;
            end
        end
    end

    assign stat_ops  = r_stat_ops;
    assign stat_errs = r_stat_errs;
`endif
endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - randomized and directed self-checking bench for alu_cmd_responder
module tb_alu_cmd_responder;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_responder_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_RSP_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    alu_cmd_responder #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef ALU_RSP_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic        zero;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        mode;
        logic        cin;
    } req_t;

    rsp_t q_exp[$];
    rsp_t q_got[$];
    req_t q_req[$];
    int   fidx;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_pops  = 0;
    int   n_errs  = 0;
    logic hold    = 1'b0;
    rsp_t hold_v;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation table, using 32-bit integer arithmetic.
    function automatic rsp_t model(input req_t r);
        int unsigned a = 32'(r.a);
        int unsigned b = 32'(r.b);
        int unsigned c = 32'(r.cin);
        int unsigned s;
        rsp_t        o = '0;
        if (!r.mode) begin
            case (r.op)
                4'd0: begin s = a + b + c; o.res = s[15:0]; o.cout = (s > 65535); end
                4'd1: begin s = a - b - c; o.res = s[15:0]; o.cout = (a < b + c); end
                4'd3: begin s = a + 1;     o.res = s[15:0]; o.cout = (a == 65535); end
                4'd4: begin s = a - 1;     o.res = s[15:0]; o.cout = (a == 0); end
                default: o.err = 1'b1;
            endcase
        end else begin
            case (r.op)
                4'd5: o.res = r.a & r.b;
                4'd6: o.res = r.a | r.b;
                4'd7: o.res = r.a ^ r.b;
                4'd8: o.res = ~r.a;
                default: o.err = 1'b1;
            endcase
        end
        o.zero = (o.res == 16'h0);
        return o;
    endfunction

    function automatic rsp_t cur_rsp();
        return {bus.rsp_result, bus.rsp_cout, bus.rsp_zero, bus.rsp_err};
    endfunction

    function automatic req_t cur_req();
        return {bus.req_a, bus.req_b, bus.req_opcode, bus.req_mode, bus.req_cin};
    endfunction

    task automatic scoreboard();
        rsp_t g;
        rsp_t e;
        g = cur_rsp();
        if (hold) begin
            check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("hold_fields", 32'(g), 32'(hold_v));
        end
        hold   = bus.rsp_valid && !bus.rsp_ready;
        hold_v = g;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q_exp.size() == 0) begin
                check_val("spurious_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = q_exp.pop_front();
                check_val("rsp", 32'(g), 32'(e));
                q_got.push_back(g);
                n_pops++;
                if (e.err) n_errs++;
            end
        end
        if (bus.req_valid && bus.req_ready) q_exp.push_back(model(cur_req()));
    endtask

    task automatic tick();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input req_t r);
        bus.req_a      = r.a;
        bus.req_b      = r.b;
        bus.req_opcode = r.op;
        bus.req_mode   = r.mode;
        bus.req_cin    = r.cin;
    endtask

    task automatic feed_step();
        logic fired;
        if (fidx < q_req.size()) begin
            set_req(q_req[fidx]);
            bus.req_valid = 1'b1;
        end else begin
            bus.req_valid = 1'b0;
        end
        fired = bus.req_valid && bus.req_ready;
        tick();
        if (fired) fidx++;
    endtask

    task automatic feed_all(input int max_cycles);
        int cyc = 0;
        while ((fidx < q_req.size() || q_exp.size() > 0) && cyc < max_cycles) begin
            feed_step();
            cyc++;
        end
        bus.req_valid = 1'b0;
        check_val("feed_drain", 32'(q_exp.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        reset_n       = 1'b0;
        #1;
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_rsp_fields", 32'(cur_rsp()), 32'd0);
        q_exp.delete();
        q_got.delete();
        q_req.delete();
        fidx   = 0;
        hold   = 1'b0;
        n_pops = 0;
        n_errs = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef ALU_RSP_STATS_EN
        check_val("rst_stat_ops", stat_ops, 32'd0);
        check_val("rst_stat_errs", 32'(stat_errs), 32'd0);
`endif
        check_val("rdy_before_edge", 32'(bus.req_ready), 32'd0);
        tick();
        check_val("rdy_after_edge", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_single(input string tag, input req_t r, input rsp_t exp);
        set_req(r);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        check_val({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check_val({tag, "_lat1"}, 32'(bus.rsp_valid), 32'd0);
        tick();
        check_val({tag, "_lat2"}, 32'(bus.rsp_valid), 32'd1);
        check_val(tag, 32'(cur_rsp()), 32'(exp));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_opcode = '0;
        bus.req_mode   = 1'b0;
        bus.req_cin    = 1'b0;
        bus.rsp_ready  = 1'b0;
        #3;
        do_reset();

        run_single("add_wrap", {16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b1, 1'b0});
        run_single("sub_cin",  {16'h0005, 16'h0005, 4'd1, 1'b0, 1'b1}, {16'hFFFF, 1'b1, 1'b0, 1'b0});
        run_single("dec_zero", {16'h0000, 16'h1234, 4'd4, 1'b0, 1'b1}, {16'hFFFF, 1'b1, 1'b0, 1'b0});
        run_single("inc_7fff", {16'h7FFF, 16'h0000, 4'd3, 1'b0, 1'b1}, {16'h8000, 1'b0, 1'b0, 1'b0});
        run_single("and",      {16'hF0F0, 16'h0FF0, 4'd5, 1'b1, 1'b1}, {16'h00F0, 1'b0, 1'b0, 1'b0});
        run_single("or",       {16'hF0F0, 16'h0FF0, 4'd6, 1'b1, 1'b0}, {16'hFFF0, 1'b0, 1'b0, 1'b0});
        run_single("xor",      {16'hF0F0, 16'h0FF0, 4'd7, 1'b1, 1'b0}, {16'hFF00, 1'b0, 1'b0, 1'b0});
        run_single("not",      {16'hF0F0, 16'h0000, 4'd8, 1'b1, 1'b1}, {16'h0F0F, 1'b0, 1'b0, 1'b0});

        // Backpressure: six offered, four accepted while the consumer stalls.
        q_req.delete();
        q_got.delete();
        fidx = 0;
        for (int i = 0; i < 6; i++) q_req.push_back({16'(i * 16'h0101), 16'h0100, 4'd0, 1'b0, 1'b0});
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed_step();
        check_val("bp_accepted", 32'(fidx), 32'd4);
        check_val("bp_ready_low", 32'(bus.req_ready), 32'd0);
        check_val("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        feed_all(40);
        check_val("bp_count", 32'(q_got.size()), 32'd6);
        if (q_got.size() == 6) check_val("bp_last", 32'(q_got[5].res), 32'h0605);

        // Illegal opcode between two ADDs.
        do_reset();
        q_req.push_back({16'h0001, 16'h0002, 4'd0, 1'b0, 1'b0});
        q_req.push_back({16'h1111, 16'h2222, 4'hF, 1'b0, 1'b1});
        q_req.push_back({16'h0003, 16'h0004, 4'd0, 1'b0, 1'b0});
        bus.rsp_ready = 1'b1;
        feed_all(30);
        check_val("ill_count", 32'(q_got.size()), 32'd3);
        if (q_got.size() == 3) begin
            check_val("ill_first", 32'(q_got[0]), 32'({16'h0003, 1'b0, 1'b0, 1'b0}));
            check_val("ill_mid", 32'(q_got[1]), 32'({16'h0000, 1'b0, 1'b1, 1'b1}));
            check_val("ill_last", 32'(q_got[2]), 32'({16'h0007, 1'b0, 1'b0, 1'b0}));
        end
`ifdef ALU_RSP_STATS_EN
        check_val("ill_stat_ops", stat_ops, 32'd3);
        check_val("ill_stat_errs", 32'(stat_errs), 32'd1);
`endif

        // Reset with three queued and one in flight.
        q_req.delete();
        fidx = 0;
        for (int i = 0; i < 4; i++) q_req.push_back({16'(i + 1), 16'h0010, 4'd0, 1'b0, 1'b0});
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed_step();
        check_val("mid_accepted", 32'(fidx), 32'd4);
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("mid_no_stale", 32'(bus.rsp_valid), 32'd0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            set_req({16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom)});
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && q_exp.size() > 0; i++) tick();
        check_val("rand_drain", 32'(q_exp.size()), 32'd0);
        check_val("rand_empty", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_RSP_STATS_EN
        check_val("rand_stat_ops", stat_ops, 32'(n_pops));
        check_val("rand_stat_errs", 32'(stat_errs), 32'(n_errs));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
